excess3_decoder: RTL and testbench
==================================

# excess3_decoder

Downstream consumer of the binary-to-Excess-3 converter. Accepts one two-digit Excess-3 code per valid/ready handshake and checks that each digit is legal. Converts legal codes back to packed BCD and to 7-bit binary. Presents the result on a held valid/ready output port and flags illegal codes and input overruns, so a converter output can be round-trip checked or handed on to binary logic.

## Interface
- CNT_W, 8, width of the error/overrun event counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- in_code  in  8  Excess-3 code; [7:4] tens digit, [3:0] ones digit (connects to converter Excess_result)
- in_valid  in  1  per-cycle strobe; a code transfers when in_valid & in_ready at a rising edge (connects to converter done)
- in_ready  out  1  block can accept a code
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- bcd_out  out  8  packed BCD {tens, ones}
- bin_out  out  7  binary value, 0..99
- out_err  out  1  current result is from an illegal code
- overrun  out  1  sticky: in_valid was seen while in_ready=0
- clr  in  1  synchronous clear of overrun and err_count
- err_count  out  CNT_W  saturating event counter

## Operation
- The FSM has four states: IDLE → CHECK → CONVERT → HOLD → IDLE.
- **IDLE**
  - in_ready=1.
  - On a transfer, latch in_code and go to CHECK.
- **CHECK**
  - A nibble is legal iff it is in 4'h3..4'hC.
  - Register the result as err_q = (tens illegal) | (ones illegal).
  - Always go to CONVERT.
- **CONVERT**
  - Digit values: tens = code[7:4]-3, ones = code[3:0]-3, each 4-bit.
  - bcd_out = {tens, ones}.
  - bin_out = tens*10 + ones, computed as (tens<<3)+(tens<<1)+ones, truncated to 7 bits.
  - If err_q=1: bcd_out=8'h00, bin_out=0, out_err=1.
  - Go to HOLD.
- **HOLD**
  - out_valid=1.
  - bcd_out, bin_out and out_err are stable until the handshake.
  - On out_valid & out_ready, go to IDLE.
- **in_ready** is 1 only in IDLE. There is no bypass, so the cycle that completes HOLD still has in_ready=0.
- **overrun**
  - Set on any edge where in_valid=1 and in_ready=0.
  - The offered code is dropped.
  - Cleared only by clr or reset.
- **err_count**
  - Increments by 1 for each illegal code, at the CHECK→CONVERT edge.
  - Increments by 1 for each overrun cycle.
  - Both events on the same edge add 2.
  - Saturates at 2^CNT_W-1.
  - clr has priority over increments: the count becomes 0 that edge.

## Timing
- Reset values: in_ready=1, out_valid=0, out_err=0, bcd_out=0, bin_out=0, overrun=0, err_count=0, FSM in IDLE.
- Reset asserted mid-operation discards the in-flight code and forces all of the above immediately, asynchronously.
- Latency: transfer at edge T0 gives out_valid=1 after edge T2, with no out_ready wait. The path is identical for legal and illegal codes.
- Minimum spacing between accepted codes is 4 cycles (IDLE, CHECK, CONVERT, HOLD with out_ready=1).
- out_valid, bcd_out, bin_out and out_err are registered, with no combinational path from inputs.
- in_ready depends only on state.
- When out_ready=0 in HOLD, the block stalls indefinitely and each in_valid cycle counts as an overrun.

## Configuration
- **E3DEC_ERRCNT_EN defined:** err_count is implemented as specified above.
- **E3DEC_ERRCNT_EN undefined:**
  - The counter logic is removed and err_count is tied to 0.
  - The port remains present.
  - overrun, out_err and all other behaviour are unchanged.

## Test plan
- Reset, then in_code=8'h3C with one in_valid pulse and out_ready=1 → out_valid after 2 edges; bcd_out=8'h09, bin_out=9, out_err=0; in_ready returns to 1 one edge after the handshake.
- Sweep upstream outputs 8'h33..8'h48 for X=0..15, one per 4 cycles → bcd_out equals X in BCD and bin_out=X for every code; err_count=0, overrun=0.
- in_code=8'h3F, then 8'h00 → each gives out_err=1, bcd_out=0, bin_out=0; err_count=2 when E3DEC_ERRCNT_EN is defined, 0 when it is not.
- in_valid held high for 10 cycles with out_ready=1 → codes accepted on cycles 0, 4 and 8; overrun=1; err_count=7 (enabled); clr pulse sets overrun=0 and err_count=0.
- out_ready=0 for 20 cycles in HOLD → outputs stable throughout; on release, handshake completes and in_ready=1 next cycle.
- Reset asserted in CONVERT → out_valid=0, in_ready=1, bcd_out=0 immediately; after release, a fresh 8'h4B yields bin_out=18.

Source files
------------

// File: rtl/excess3_decoder.sv
// excess3_decoder
//
// Accepts one two-digit Excess-3 code per valid/ready handshake and checks
// that each digit is legal (nibble in 3..12). Legal codes are converted back
// to packed BCD and to a 7-bit binary value; illegal codes produce zeros
// and raise o_out_err. The result is held on a valid/ready output port.
//
// Processing walks IDLE -> CHECK -> CONVERT -> HOLD -> IDLE. A code is only
// accepted in IDLE, so codes are at least four cycles apart. Any code offered
// while busy is dropped and sets the sticky overrun flag.
//
// Build option:
//   E3DEC_ERRCNT_EN  defined   -> o_err_count is a saturating counter of
//                                 illegal codes plus overrun cycles.
//                    undefined -> counter removed, o_err_count tied to 0.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous reset, active-low
//   i_in_code    Excess-3 code, [7:4] tens digit, [3:0] ones digit
//   i_in_valid   code strobe; transfers when i_in_valid & o_in_ready
//   o_in_ready   block can accept a code (IDLE only)
//   o_out_valid  result held valid
//   i_out_ready  consumer accepts result
//   o_bcd_out    packed BCD {tens, ones}
//   o_bin_out    binary value 0..99
//   o_out_err    current result came from an illegal code
//   o_overrun    sticky: a code was offered while busy
//   i_clr        synchronous clear of o_overrun and o_err_count
//   o_err_count  saturating error/overrun event counter (CNT_W bits)

module excess3_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_in_code,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_bcd_out,
  output logic [6:0]       o_bin_out,
  output logic             o_out_err,
  output logic             o_overrun,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_err_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_CONVERT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_code;
  logic       r_err_q;
  logic       r_out_valid;
  logic [7:0] r_bcd;
  logic [6:0] r_bin;
  logic       r_out_err;
  logic       r_overrun;

  logic       w_in_ready;
  logic       w_tens_ok;
  logic       w_ones_ok;
  logic       w_code_err;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [6:0] w_tens7;
  logic [6:0] w_ones7;
  logic [6:0] w_bin;
  logic       w_overrun_evt;

  // Ready is a pure function of state: no bypass from the output handshake.
  assign w_in_ready = (r_state == S_IDLE);

  // Digit legality of the latched code.
  assign w_tens_ok  = (r_code[7:4] >= 4'h3) && (r_code[7:4] <= 4'hC);
  assign w_ones_ok  = (r_code[3:0] >= 4'h3) && (r_code[3:0] <= 4'hC);
  assign w_code_err = ~w_tens_ok | ~w_ones_ok;

  // Digit values and tens*10 + ones using shifts; only used for legal codes,
  // where tens <= 9 keeps the result within 7 bits.
  assign w_tens  = r_code[7:4] - 4'd3;
  assign w_ones  = r_code[3:0] - 4'd3;
  assign w_tens7 = {3'b000, w_tens};
  assign w_ones7 = {3'b000, w_ones};
  assign w_bin   = (w_tens7 << 3) + (w_tens7 << 1) + w_ones7;

  // A code offered while busy is dropped and flagged.
  assign w_overrun_evt = i_in_valid & ~w_in_ready;

  // Main FSM with registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_code      <= 8'h00;
      r_err_q     <= 1'b0;
      r_out_valid <= 1'b0;
      r_bcd       <= 8'h00;
      r_bin       <= 7'd0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_code  <= i_in_code;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err_q <= w_code_err;
          r_state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (r_err_q) begin
            r_bcd     <= 8'h00;
            r_bin     <= 7'd0;
            r_out_err <= 1'b1;
          end else begin
            r_bcd     <= {w_tens, w_ones};
            r_bin     <= w_bin;
            r_out_err <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          // Result registers keep their values after the handshake; only
          // the valid flag drops.
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; clear wins over a same-cycle set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_evt) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef E3DEC_ERRCNT_EN
  logic [CNT_W-1:0] r_err_count;
  logic             w_check_err_evt;
  logic [1:0]       w_inc;
  logic [CNT_W:0]   w_sum;

  // Illegal-code event lands on the CHECK -> CONVERT edge; it may coincide
  // with an overrun event, in which case both count.
  assign w_check_err_evt = (r_state == S_CHECK) & w_code_err;
  assign w_inc = {1'b0, w_check_err_evt} + {1'b0, w_overrun_evt};
  assign w_sum = {1'b0, r_err_count} + (CNT_W+1)'(w_inc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
    end else if (i_clr) begin
      r_err_count <= '0;
    end else if (w_sum[CNT_W]) begin
      r_err_count <= {CNT_W{1'b1}};
    end else begin
      r_err_count <= w_sum[CNT_W-1:0];
    end
  end

  assign o_err_count = r_err_count;
`else
  assign o_err_count = '0;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_bcd_out   = r_bcd;
  assign o_bin_out   = r_bin;
  assign o_out_err   = r_out_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_excess3_decoder.sv
// Testbench for excess3_decoder: directed boundary cases plus randomized
// codes, stalls and overrun noise, checked against an arithmetic model.

module tb_excess3_decoder;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [7:0]       in_code;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       bcd_out;
  logic [6:0]       bin_out;
  logic             out_err;
  logic             overrun;
  logic             clr;
  logic [CNT_W-1:0] err_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: total events since last clear/reset, overrun flag.
  int exp_cnt = 0;
  bit exp_ovr = 1'b0;

  excess3_decoder #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_code   (in_code),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_bcd_out   (bcd_out),
    .o_bin_out   (bin_out),
    .o_out_err   (out_err),
    .o_overrun   (overrun),
    .i_clr       (clr),
    .o_err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_count_now();
`ifdef E3DEC_ERRCNT_EN
    return (exp_cnt > CNT_MAX) ? CNT_MAX : exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // noise: 0 none, 1 random in_valid, 2 in_valid always high while busy.
  task automatic busy_drive(input int noise);
    case (noise)
      1:       in_valid = 1'($urandom_range(0, 1));
      2:       in_valid = 1'b1;
      default: in_valid = 1'b0;
    endcase
    in_code = 8'($urandom);
    if (in_valid) begin
      exp_ovr = 1'b1;
      exp_cnt++;
    end
  endtask

  // Full transaction starting in IDLE, ending one cycle after the handshake.
  task automatic send_code(input logic [7:0] code, input int stall, input int noise);
    int  t, o;
    bit  legal;
    logic [7:0] e_bcd;
    logic [6:0] e_bin;
    t = int'(code[7:4]);
    o = int'(code[3:0]);
    legal = (t >= 3) && (t <= 12) && (o >= 3) && (o <= 12);
    e_bcd = legal ? 8'(((t - 3) << 4) | (o - 3)) : 8'h00;
    e_bin = legal ? 7'((t - 3) * 10 + (o - 3)) : 7'd0;
    if (!legal) exp_cnt++;

    check("idle_ready", 32'(in_ready), 32'd1);
    in_code   = code;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    step();                                   // CHECK
    check("chk_ready", 32'(in_ready), 32'd0);
    check("chk_valid", 32'(out_valid), 32'd0);
    busy_drive(noise);
    step();                                   // CONVERT
    check("cvt_valid", 32'(out_valid), 32'd0);
    busy_drive(noise);
    step();                                   // HOLD
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_ready", 32'(in_ready), 32'd0);
    check("bcd", 32'(bcd_out), 32'(e_bcd));
    check("bin", 32'(bin_out), 32'(e_bin));
    check("err", 32'(out_err), 32'(!legal));
    for (int i = 0; i < stall; i++) begin
      busy_drive(noise);
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_bcd", 32'(bcd_out), 32'(e_bcd));
      check("stall_bin", 32'(bin_out), 32'(e_bin));
      check("stall_err", 32'(out_err), 32'(!legal));
    end
    out_ready = 1'b1;
    busy_drive(noise);
    step();                                   // back in IDLE
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("err_count", 32'(err_count), 32'(exp_count_now()));
    $display("txn code=%02h stall=%0d bcd=%02h bin=%0d err=%0b ovr=%0b cnt=%0d",
             code, stall, bcd_out, bin_out, out_err, overrun, err_count);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    exp_ovr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [7:0] code;
    rst_n = 1'b0; in_code = 8'h00; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    step();
    step();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();

    // First code: 9.
    send_code(8'h3C, 0, 0);

    // Upstream sweep X = 0..15.
    for (int x = 0; x < 16; x++) begin
      code = 8'((((x / 10) + 3) << 4) | ((x % 10) + 3));
      send_code(code, 0, 0);
    end

    // Illegal codes and digit-range boundaries.
    send_code(8'h3F, 0, 0);
    send_code(8'h00, 0, 0);
    send_code(8'hCC, 0, 0);
    send_code(8'h33, 0, 0);
    send_code(8'hD3, 0, 0);
    send_code(8'h2C, 0, 0);
    send_code(8'hC2, 0, 0);
    send_code(8'h3D, 0, 0);
    pulse_clr();

    // in_valid held high for 10 cycles: accepts on cycles 0, 4, 8.
    in_code = 8'h45; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("burst_ready", 32'(in_ready), 32'((i % 4) == 0));
      if ((i % 4) != 0) begin
        exp_cnt++;
        exp_ovr = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    step();                                   // HOLD of third code
    check("burst_valid", 32'(out_valid), 32'd1);
    check("burst_bin", 32'(bin_out), 32'd12);
    check("burst_bcd", 32'(bcd_out), 32'h12);
    step();
    out_ready = 1'b0;
    check("burst_idle", 32'(in_ready), 32'd1);
    check("burst_overrun", 32'(overrun), 32'd1);
    check("burst_count", 32'(err_count), 32'(exp_count_now()));
    pulse_clr();

    // Long stall with quiet input, then long stall driving the counter to
    // saturation.
    send_code(8'h47, 20, 0);
    send_code(8'h58, 300, 2);
    pulse_clr();

    // Randomized codes, stalls and overrun noise.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 6)
        code = {4'($urandom_range(3, 12)), 4'($urandom_range(3, 12))};
      else
        code = 8'($urandom);
      send_code(code, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    // Reset asserted while in CONVERT.
    send_code(8'h4C, 0, 0);
    in_code = 8'h45; in_valid = 1'b1;
    step();                                   // CHECK
    in_valid = 1'b0;
    step();                                   // CONVERT
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_ovr = 1'b0;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_bcd", 32'(bcd_out), 32'd0);
    check("arst_bin", 32'(bin_out), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_count", 32'(err_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_code(8'h4B, 0, 0);
    check("fresh_bin", 32'(bin_out), 32'd18);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
